// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all downstream resets after power-on or a request,
// then releases them one stage at a time, lowest index first.
module reset_sequencer #(
  parameter int unsigned HoldCycles   = 50000000,
  parameter int unsigned StageGap     = 16,
  parameter int unsigned Stages       = 4,
  parameter int unsigned CounterWidth =
    $clog2((HoldCycles > StageGap ? HoldCycles : StageGap) + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic [Stages-1:0] rst_out,
  output logic              busy,
  output logic              done
);
  localparam int unsigned StgW = $clog2(Stages + 1);
  localparam logic [CounterWidth-1:0] HoldLast = CounterWidth'(HoldCycles - 1);
  localparam logic [CounterWidth-1:0] GapLast  = CounterWidth'(StageGap - 1);
  localparam logic [StgW-1:0]         StgLast  = StgW'(Stages - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, IDLE} state_e;

  state_e            state_q, state_d;
  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [StgW-1:0]   stg_q, stg_d;
  logic [Stages-1:0] rst_out_q, rst_out_d;
  logic              busy_q, done_q, done_d;
  logic              s1_q, s2_q, s3_q, req_rise;

  // Two-flop synchronizer plus one stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= req;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign req_rise = s2_q & ~s3_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stg_d     = stg_q;
    rst_out_d = rst_out_q;
    done_d    = 1'b0;
    if (req_rise) begin
      state_d   = HOLD;
      cnt_d     = '0;
      stg_d     = '0;
      rst_out_d = '1;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HoldLast) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            stg_d        = StgW'(1);
            if (Stages == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == GapLast) begin
            for (int i = 0; i < int'(Stages); i++) begin
              if (StgW'(i) == stg_q) rst_out_d[i] = 1'b0;
            end
            cnt_d = '0;
            stg_d = stg_q + 1'b1;
            if (stg_q == StgLast) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        IDLE: begin
          rst_out_d = '0;
          cnt_d     = '0;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  // busy tracks the next rst_out value so both register on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      stg_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stg_q     <= stg_d;
      rst_out_q <= rst_out_d;
      busy_q    <= |rst_out_d;
      done_q    <= done_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on timing, requests in each state,
// async reset mid-release, and a single-stage build.
module tb_reset_sequencer;
  localparam int H = 10;
  localparam int G = 3;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst_n, req;
  logic [2:0] rst_out;
  logic       busy, done;
  logic       rst_n2, req2;
  logic [0:0] rst_out2;
  logic       busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.HoldCycles(H), .StageGap(G), .Stages(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .rst_out(rst_out), .busy(busy), .done(done)
  );

  reset_sequencer #(.HoldCycles(1), .StageGap(1), .Stages(1)) dut1 (
    .clk(clk), .rst_n(rst_n2), .req(req2),
    .rst_out(rst_out2), .busy(busy2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected rst_out n edges into a sequence (edge 1 = first edge of the hold).
  function automatic logic [2:0] exp_out(input int n);
    logic [2:0] r;
    for (int k = 0; k < S; k++) r[k] = (n < H + k * G);
    return r;
  endfunction

  task automatic run_seq(input int n0, input int cyc, input string tag, output int dones);
    int n;
    dones = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      n = n0 + i;
      checks++;
      if (rst_out !== exp_out(n)) begin
        errors++;
        $display("FAIL %s rst_out n=%0d got %b exp %b", tag, n, rst_out, exp_out(n));
      end
      checks++;
      if (done !== (n == H + (S - 1) * G)) begin
        errors++;
        $display("FAIL %s done n=%0d got %b exp %b", tag, n, done, (n == H + (S - 1) * G));
      end
      checks++;
      if (busy !== (exp_out(n) != 3'b000)) begin
        errors++;
        $display("FAIL %s busy n=%0d got %b exp %b", tag, n, busy, (exp_out(n) != 3'b000));
      end
      if (done === 1'b1) dones++;
    end
  endtask

  task automatic check_all_on(input string tag);
    checks++;
    if (rst_out !== 3'b111 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s got rst_out=%b busy=%b done=%b exp 111/1/0", tag, rst_out, busy, done);
    end
  endtask

  task automatic check_dones(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s done_pulses got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    check_all_on("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_power_on();
    int d, d2;
    test_reset();
    run_seq(1, 17, "pwr", d);
    check_dones("pwr", d, 1);
    run_seq(18, 12, "pwr_idle", d2);
    check_dones("pwr_idle", d2, 0);
  endtask

  // Continues from edge 29 of the power-on run.
  task automatic test_idle_req();
    int d0, d1, d2;
    req = 1'b1;
    run_seq(30, 2, "idle_sync", d0);
    tick();
    check_all_on("idle_act");
    run_seq(1, 2, "idle_a", d1);
    req = 1'b0;
    run_seq(3, 16, "idle_b", d2);
    check_dones("idle_req", d0 + d1 + d2, 1);
  endtask

  task automatic test_req_hold();
    int d0, d1;
    test_reset();
    run_seq(1, 4, "hold_pre", d0);
    req = 1'b1;
    run_seq(5, 3, "hold_sync", d1);
    req = 1'b0;
    run_seq(1, 18, "hold_restart", d1);
    check_dones("hold_req", d0 + d1, 1);
  endtask

  task automatic test_req_release();
    int d0, d1;
    test_reset();
    run_seq(1, 13, "rel_pre", d0);
    req = 1'b1;
    run_seq(14, 2, "rel_sync", d0);
    tick();
    check_all_on("rel_act");
    req = 1'b0;
    run_seq(1, 17, "rel_restart", d1);
    check_dones("rel_req", d0 + d1, 1);
  endtask

  task automatic test_async_reset();
    int d;
    test_reset();
    run_seq(1, 10, "async_pre", d);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_on("async_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1, 17, "async_post", d);
    check_dones("async_post", d, 1);
  endtask

  task automatic test_single_stage();
    int extra;
    rst_n2 = 1'b0;
    req2   = 1'b0;
    @(negedge clk);
    checks++;
    if (rst_out2 !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL s1_reset got %b/%b/%b exp 1/1/0", rst_out2, busy2, done2);
    end
    @(negedge clk);
    rst_n2 = 1'b1;
    tick();
    checks++;
    if (rst_out2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL s1_edge1 got %b/%b/%b exp 0/0/1", rst_out2, busy2, done2);
    end
    tick();
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL s1_edge2 done got %b exp 0", done2);
    end
    req2 = 1'b1;
    tick();
    tick();
    checks++;
    if (rst_out2 !== 1'b0) begin
      errors++;
      $display("FAIL s1_sync rst_out got %b exp 0", rst_out2);
    end
    tick();
    checks++;
    if (rst_out2 !== 1'b1 || busy2 !== 1'b1 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL s1_act got %b/%b/%b exp 1/1/0", rst_out2, busy2, done2);
    end
    tick();
    checks++;
    if (rst_out2 !== 1'b0 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL s1_rel got rst_out=%b done=%b exp 0/1", rst_out2, done2);
    end
    extra = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (rst_out2 !== 1'b0 || done2 !== 1'b0) extra++;
    end
    req2 = 1'b0;
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL s1_held_req extra_activity got %0d exp 0", extra);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 1'b0;
    rst_n2 = 1'b0;
    req2   = 1'b0;
    test_power_on();
    test_idle_req();
    test_req_hold();
    test_req_release();
    test_async_reset();
    test_single_stage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-on and on-demand reset generator for the design's clock domain. After asynchronous reset, or on a synchronized request from a button or soft-reset source, it holds every downstream reset asserted for a fixed number of clocks. It then releases the reset outputs one stage at a time, spaced by a fixed gap. It sits between the board-level reset/request inputs and the functional blocks, which consume its active-high `rst_out` bits as their synchronous resets.

## Interface
- `HoldCycles`, default 50000000, number of clocks all stages stay asserted; must be >= 1.
- `StageGap`, default 16, clocks between consecutive stage releases; must be >= 1.
- `Stages`, default 4, number of reset outputs; must be >= 1.
- `CounterWidth`, default `$clog2((HoldCycles > StageGap ? HoldCycles : StageGap) + 1)`, width of the shared counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  1  reset request; asynchronous level; only its rising edge acts.
- `rst_out`  out  `Stages`  active-high resets; bit 0 released first.
- `busy`  out  1  high while any `rst_out` bit is asserted.
- `done`  out  1  one-cycle pulse when the last stage releases.

## Operation
- States: HOLD, RELEASE, IDLE. One shared counter `cnt`, one stage index `stg`.
- While `rst_n`=0, asynchronously and immediately:
  - state=HOLD, `cnt`=0, `stg`=0
  - `rst_out`=all ones, `busy`=1, `done`=0
  - all synchronizer flops=0
- `req` path: two-flop synchronizer, then a registered copy for edge detect. The rising-edge strobe `req_rise` = s2 & ~s3.
- HOLD:
  - `cnt` increments each clock.
  - When `cnt`==HoldCycles-1: clear `rst_out[0]`, `cnt`=0, `stg`=1, go to RELEASE.
  - If Stages==1, go to IDLE instead, with `done`=1.
- RELEASE:
  - `cnt` increments each clock.
  - When `cnt`==StageGap-1: clear `rst_out[stg]`, `cnt`=0, `stg`+1.
  - If `stg` was Stages-1, go to IDLE with `done`=1 on that same edge.
- IDLE: `rst_out`=0, `busy`=0, counter frozen at 0.
- `req_rise` has priority over all counting in every state:
  - `rst_out`=all ones, `cnt`=0, `stg`=0, go to HOLD, `done`=0.
  - In HOLD this restarts (extends) the hold.
  - In RELEASE it re-asserts the stages already released.
- `req` held high produces exactly one sequence. A new sequence requires `req` to fall and rise again.
- `rst_out` bits only change from 1 to 0 in ascending index order, never out of order. A higher bit is never 0 while a lower bit is 1.
- `busy` = OR of `rst_out`, registered consistently with `rst_out` (no extra cycle).

## Timing
- Edge numbering: edge 1 is the first rising `clk` edge with `rst_n`=1.
- Power-on release times:
  - `rst_out[k]` falls at edge HoldCycles + k*StageGap.
  - `done` is high for exactly the cycle after edge HoldCycles + (Stages-1)*StageGap.
  - `busy` falls on that same edge.
- Request latency: if `req` rises before edge e, s1=1 at e and s2=1 at e+1. Action registers at edge e+2, where `rst_out` becomes all ones.
- After a request, the release schedule above applies with edge 1 replaced by edge e+3.
- `req` pulses shorter than one clock may be missed; `req` must stay high >= 2 clocks to be guaranteed.
- `rst_n` assertion mid-sequence: outputs go to reset values without waiting for `clk`.
- Counter never exceeds max(HoldCycles, StageGap)-1; no wrap-around occurs.

## Test plan
- Power-on, with HoldCycles=10, StageGap=3, Stages=3:
  - `rst_out` reads 3'b111 through edge 9.
  - Then 3'b110 at edge 10, 3'b100 at edge 13, 3'b000 at edge 16.
  - `done`=1 only for the cycle after edge 16; `busy` falls at edge 16.
- IDLE request: `req` rises before edge 30 and is held 5 clocks.
  - `rst_out`=3'b111 at edge 32.
  - Bits release at edges 42, 45, 48.
  - Exactly one `done` pulse.
- Request during HOLD: `req` rises before edge 5 of power-on.
  - `rst_out` stays 3'b111.
  - First release moves to edge 7+10=17.
- Request during RELEASE: `req` rising edge detected when `rst_out`=3'b100.
  - `rst_out` returns to 3'b111 at the action edge.
  - `done` is not pulsed.
  - Full schedule restarts.
- Async reset mid-release: `rst_n` driven low between edges while `rst_out`=3'b110.
  - `rst_out`=3'b111, `busy`=1, `done`=0 before the next edge.
  - After `rst_n` release, power-on timing repeats.
- Stages=1, StageGap=1, HoldCycles=1:
  - `rst_out` falls at edge 1, with `done` pulsed the following cycle.
  - `req` held high for 20 clocks triggers only one sequence.
